audio_level_meter_led_driver: RTL and testbench

//   Consumer end of the level meter's indicator-array stream. Accepts one WIDTH-bit bar

---
 rtl/audio_level_meter_led_driver_pkg.sv | 16 +
 rtl/audio_level_meter_led_driver_phase_timer.sv | 37 +++
 rtl/audio_level_meter_led_driver.sv | 151 +++++++++++++++
 tb/tb_audio_level_meter_led_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_level_meter_led_driver_pkg.sv
// Shared types for the LED chain driver: FSM state encoding and a small
// constant helper used to size the phase timer.
package audio_level_meter_led_driver_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } led_state_e;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/audio_level_meter_led_driver_phase_timer.sv
// Phase down-counter shared by every serial-clock half-period and by the
// latch pulse. Loading N-1 makes 'done' appear N cycles after the load edge.
module led_shift_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously so a reset abandons any phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/audio_level_meter_led_driver.sv
// Serialises one bar pattern per handshake into a 74HC595-style LED chain:
// data is set up while o_sclk is low, sampled on its rising edge, and the
// whole frame is committed with a single o_latch pulse after the last bit.
module audio_level_meter_led_driver
  import audio_level_meter_led_driver_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2,
  parameter int MSB_FIRST    = 1,
  parameter int INVERT       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_array,
  output logic             o_sclk,
  output logic             o_sdata,
  output logic             o_latch
);

  localparam int CNT_W = $clog2(max_of(CLK_DIV, LATCH_CYCLES) + 1);
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);

  led_state_e        state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ready_q, ready_d;
  logic              sclk_q, sclk_d;
  logic              sdata_q, sdata_d;
  logic              latch_q, latch_d;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;
  logic [WIDTH-1:0]  captured;

  // The bit that goes onto the wire next always sits at the head of the register.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  assign captured = (INVERT != 0) ? ~i_array : i_array;

  led_shift_phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (tmr_load),
    .i_load_val(tmr_val),
    .o_done    (tmr_done)
  );

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ready_d   = ready_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    latch_d   = latch_q;
    tmr_load  = 1'b0;
    tmr_val   = DIV_LOAD;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        latch_d = 1'b0;
        if (i_valid && ready_q) begin
          shreg_d   = captured;
          bit_cnt_d = '0;
          ready_d   = 1'b0;
          sdata_d   = head_bit(captured);
          tmr_load  = 1'b1;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tmr_done) begin
          sclk_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tmr_done) begin
          sclk_d   = 1'b0;
          tmr_load = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            latch_d = 1'b1;
            tmr_val = LATCH_LOAD;
            state_d = LATCH;
          end else begin
            shreg_d   = advance(shreg_q);
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            sdata_d   = head_bit(advance(shreg_q));
            state_d   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (tmr_done) begin
          latch_d = 1'b0;
          ready_d = 1'b1;
          sdata_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered pin drivers; reset drops everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      latch_q   <= latch_d;
    end
  end

  assign i_ready = ready_q;
  assign o_sclk  = sclk_q;
  assign o_sdata = sdata_q;
  assign o_latch = latch_q;

endmodule

// File: tb/tb_audio_level_meter_led_driver.sv
// Directed bench for the LED chain driver. Four configurations run side by
// side: 0 = default (W8,DIV2,MSB), 1 = inverted, 2 = LSB first, 3 = W32 DIV1.
module tb_audio_level_meter_led_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  valid = '0;
  logic [7:0]  arr0 = '0;
  logic [7:0]  arr1 = '0;
  logic [7:0]  arr2 = '0;
  logic [31:0] arr3 = '0;
  logic [3:0]  ready_w;
  logic [3:0]  sclk_w;
  logic [3:0]  sdata_w;
  logic [3:0]  latch_w;

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;

  logic [3:0]  sclk_prev = '0;
  logic [3:0]  sdata_prev = '0;
  logic [3:0]  latch_prev = '0;
  logic [3:0]  ready_prev = '0;
  logic [31:0] bits [4];
  int rises [4];
  int glitches [4];
  int latch_rises [4];
  int latch_len [4];
  int latch_falls [4];
  int fall_cyc [4];
  int ready_rise_cyc [4];
  int accept_cyc [4];

  audio_level_meter_led_driver #(.WIDTH(8), .CLK_DIV(2), .LATCH_CYCLES(2), .MSB_FIRST(1), .INVERT(0)) dut0 (
    .clk(clk), .reset(reset), .i_valid(valid[0]), .i_ready(ready_w[0]), .i_array(arr0),
    .o_sclk(sclk_w[0]), .o_sdata(sdata_w[0]), .o_latch(latch_w[0]));

  audio_level_meter_led_driver #(.WIDTH(8), .CLK_DIV(2), .LATCH_CYCLES(2), .MSB_FIRST(1), .INVERT(1)) dut1 (
    .clk(clk), .reset(reset), .i_valid(valid[1]), .i_ready(ready_w[1]), .i_array(arr1),
    .o_sclk(sclk_w[1]), .o_sdata(sdata_w[1]), .o_latch(latch_w[1]));

  audio_level_meter_led_driver #(.WIDTH(8), .CLK_DIV(2), .LATCH_CYCLES(2), .MSB_FIRST(0), .INVERT(0)) dut2 (
    .clk(clk), .reset(reset), .i_valid(valid[2]), .i_ready(ready_w[2]), .i_array(arr2),
    .o_sclk(sclk_w[2]), .o_sdata(sdata_w[2]), .o_latch(latch_w[2]));

  audio_level_meter_led_driver #(.WIDTH(32), .CLK_DIV(1), .LATCH_CYCLES(2), .MSB_FIRST(1), .INVERT(0)) dut3 (
    .clk(clk), .reset(reset), .i_valid(valid[3]), .i_ready(ready_w[3]), .i_array(arr3),
    .o_sclk(sclk_w[3]), .o_sdata(sdata_w[3]), .o_latch(latch_w[3]));

  // Free-running clock and edge counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: records the bit seen at each o_sclk rise, latch pulses and handshake edges.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (sclk_w[k] && !sclk_prev[k]) begin
        rises[k]++;
        bits[k] = {bits[k][30:0], sdata_w[k]};
      end
      if (sclk_w[k] && sclk_prev[k] && (sdata_w[k] != sdata_prev[k])) glitches[k]++;
      if (latch_w[k] && !latch_prev[k]) begin
        latch_rises[k]++;
        latch_len[k] = 0;
      end
      if (latch_w[k]) latch_len[k]++;
      if (!latch_w[k] && latch_prev[k]) begin
        latch_falls[k]++;
        fall_cyc[k] = cyc;
      end
      if (ready_w[k] && !ready_prev[k]) ready_rise_cyc[k] = cyc;
      if (!ready_w[k] && ready_prev[k]) accept_cyc[k] = cyc;
      sclk_prev[k]  = sclk_w[k];
      sdata_prev[k] = sdata_w[k];
      latch_prev[k] = latch_w[k];
      ready_prev[k] = ready_w[k];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input int k);
    bits[k] = '0;
    rises[k] = 0;
    glitches[k] = 0;
    latch_rises[k] = 0;
    latch_len[k] = 0;
    latch_falls[k] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one frame to instance k for a single edge; the instance must be ready.
  task automatic applyStimulus(input int k, input logic [31:0] data);
    case (k)
      0: arr0 = data[7:0];
      1: arr1 = data[7:0];
      2: arr2 = data[7:0];
      default: arr3 = data;
    endcase
    valid[k] = 1'b1;
    step();
    valid[k] = 1'b0;
  endtask

  task automatic wait_frame(input int k, input string tag);
    int n = 0;
    while (latch_falls[k] == 0 && n < 400) begin
      step();
      n++;
    end
    checkOutput({tag, "_frame_done"}, 32'(latch_falls[k] != 0), 32'd1);
  endtask

  initial begin
    int a1;
    for (int k = 0; k < 4; k++) begin
      bits[k] = '0; rises[k] = 0; glitches[k] = 0; latch_rises[k] = 0; latch_len[k] = 0;
      latch_falls[k] = 0; fall_cyc[k] = 0; ready_rise_cyc[k] = 0; accept_cyc[k] = 0;
    end

    // Reset held with a frame offered: nothing may move.
    #1 reset = 1'b0;
    arr0 = 8'hA5;
    valid[0] = 1'b1;
    repeat (3) step();
    checkOutput("rst_ready", 32'(ready_w[0]), 32'd0);
    checkOutput("rst_sclk", 32'(sclk_w[0]), 32'd0);
    checkOutput("rst_sdata", 32'(sdata_w[0]), 32'd0);
    checkOutput("rst_latch", 32'(latch_w[0]), 32'd0);
    checkOutput("rst_ready_all", 32'(ready_w), 32'h0);

    // Release: ready one edge later, then 8'hA5 is accepted on the next edge.
    reset = 1'b1;
    clear_mon(0);
    step();
    checkOutput("ready_after_reset", 32'(ready_w[0]), 32'd1);
    step();
    checkOutput("ready_drop_on_accept", 32'(ready_w[0]), 32'd0);
    checkOutput("first_bit_a5", 32'(sdata_w[0]), 32'd1);
    valid[0] = 1'b0;
    arr0 = 8'h00;
    wait_frame(0, "a5");
    checkOutput("a5_bits", bits[0][7:0], 32'hA5);
    checkOutput("a5_rises", rises[0], 8);
    checkOutput("a5_latch_pulses", latch_rises[0], 1);
    checkOutput("a5_latch_len", latch_len[0], 2);
    checkOutput("a5_latency", fall_cyc[0] - accept_cyc[0], 34);
    checkOutput("a5_ready_at_fall", ready_rise_cyc[0], fall_cyc[0]);
    checkOutput("a5_glitch", glitches[0], 0);
    checkOutput("a5_idle_sdata", 32'(sdata_w[0]), 32'd0);

    // Back-to-back: i_valid held across 8'hFF then 8'h00.
    clear_mon(0);
    arr0 = 8'hFF;
    valid[0] = 1'b1;
    step();
    arr0 = 8'h00;
    wait_frame(0, "ff");
    a1 = accept_cyc[0];
    checkOutput("ff_bits", bits[0][7:0], 32'hFF);
    checkOutput("ff_rises", rises[0], 8);
    checkOutput("ff_latency", fall_cyc[0] - a1, 34);
    checkOutput("ff_ready_at_fall", ready_rise_cyc[0], fall_cyc[0]);
    clear_mon(0);
    valid[0] = 1'b0;
    wait_frame(0, "b2b");
    checkOutput("b2b_period", accept_cyc[0] - a1, 35);
    checkOutput("b2b_bits", bits[0][7:0], 32'h00);
    checkOutput("b2b_rises", rises[0], 8);
    checkOutput("b2b_latch_len", latch_len[0], 2);

    // Reset pulse after the third serial clock rise of a 8'h3C frame.
    clear_mon(0);
    applyStimulus(0, 32'h3C);
    for (int n = 0; n < 100 && rises[0] < 3; n++) step();
    checkOutput("mid_rises_before_reset", rises[0], 3);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_sclk", 32'(sclk_w[0]), 32'd0);
    checkOutput("mid_rst_sdata", 32'(sdata_w[0]), 32'd0);
    checkOutput("mid_rst_latch", 32'(latch_w[0]), 32'd0);
    checkOutput("mid_rst_ready", 32'(ready_w[0]), 32'd0);
    step();
    step();
    checkOutput("mid_no_latch", latch_rises[0], 0);
    reset = 1'b1;
    clear_mon(0);
    arr0 = 8'h81;
    valid[0] = 1'b1;
    step();
    step();
    valid[0] = 1'b0;
    wait_frame(0, "x81");
    checkOutput("x81_bits", bits[0][7:0], 32'h81);
    checkOutput("x81_rises", rises[0], 8);
    checkOutput("x81_latch_pulses", latch_rises[0], 1);

    // Inverted, LSB-first and wide configurations launched together.
    for (int k = 1; k < 4; k++) clear_mon(k);
    arr1 = 8'h0F;
    arr2 = 8'h01;
    arr3 = 32'hDEADBEEF;
    valid[3:1] = 3'b111;
    step();
    valid[3:1] = 3'b000;
    arr1 = 8'hFF;
    arr3 = 32'h0;
    wait_frame(1, "inv");
    checkOutput("inv_bits", bits[1][7:0], 32'hF0);
    checkOutput("inv_idle_sdata", 32'(sdata_w[1]), 32'd0);
    wait_frame(2, "lsb");
    checkOutput("lsb_bits", bits[2][7:0], 32'h80);
    checkOutput("lsb_rises", rises[2], 8);
    wait_frame(3, "w32");
    checkOutput("w32_bits", bits[3], 32'hDEADBEEF);
    checkOutput("w32_rises", rises[3], 32);
    checkOutput("w32_latency", fall_cyc[3] - accept_cyc[3], 66);
    checkOutput("w32_glitch", glitches[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
